uart_tx32: RTL and testbench

UART_TX32 -- requirements
Module: uart_tx32

---
 rtl/uart_tx32.sv | 130 +++++++++++++
 tb/tb_uart_tx32.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx32.sv
// 32-bit word UART transmitter: four 8N1 frames, MSB byte first, LSB bit first.
// One-cycle DONE state sits between words; it can accept the next word directly.
module uart_tx32 #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [1:0]  byte_idx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [31:0]   shreg, shreg_n;
    logic [1:0]    byte_idx_n;
    logic          tx_out_n, tx_done_n;
    logic          accept, bit_end;

    assign tx_ready = (state == IDLE) || (state == DONE);
    assign tx_busy  = (state == START) || (state == DATA) || (state == STOP);
    assign accept   = tx_valid && tx_ready;
    assign bit_end  = (clk_cnt == LAST_CLK);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            tx_out   <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            byte_idx <= byte_idx_n;
            tx_out   <= tx_out_n;
            tx_done  <= tx_done_n;
        end
    end

    // tx_out is registered, so each branch loads the level for the bit that starts next cycle.
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        byte_idx_n = byte_idx;
        tx_out_n   = tx_out;
        tx_done_n  = 1'b0;
        case (state)
            IDLE, DONE: begin
                tx_out_n   = 1'b1;
                byte_idx_n = '0;
                state_n    = IDLE;
                if (accept) begin
                    state_n   = START;
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    shreg_n   = tx_data;
                    tx_out_n  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    tx_out_n  = shreg[24];
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        // top byte consumed: bring the next byte into [31:24]
                        state_n  = STOP;
                        tx_out_n = 1'b1;
                        shreg_n  = {shreg[23:0], 8'h00};
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shreg_n   = {1'b0, shreg[31:25], shreg[23:0]};
                        tx_out_n  = shreg[25];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (byte_idx == 2'd3) begin
                        state_n    = DONE;
                        tx_done_n  = 1'b1;
                        tx_out_n   = 1'b1;
                        byte_idx_n = '0;
                    end else begin
                        state_n    = START;
                        byte_idx_n = byte_idx + 2'd1;
                        tx_out_n   = 1'b0;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_n  = IDLE;
                tx_out_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx32.sv
// Bench for uart_tx32 at CLKS_PER_BIT=10: per-cycle line compare against an expected
// waveform built from the framing rules, plus a mid-bit sampling receiver.
module tb_uart_tx32;

    localparam int CF   = 100;
    localparam int BR   = 10;
    localparam int C    = CF / BR;
    localparam int WORD = 40 * C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_out, tx_busy, tx_done;
    logic [1:0]  byte_idx;

    int vectors = 0;
    int miscompares = 0;
    logic exp_line[$];

    always #5 clk = ~clk;

    uart_tx32 #(.CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy),
        .tx_done(tx_done), .byte_idx(byte_idx)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, expected $finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level for each cycle after acceptance: per byte, start, 8 data LSB first, stop.
    task automatic build_line(input logic [31:0] w);
        logic [7:0] by;
        exp_line.delete();
        for (int b = 0; b < 4; b++) begin
            by = w[31-8*b -: 8];
            repeat (C) exp_line.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (C) exp_line.push_back(by[i]);
            repeat (C) exp_line.push_back(1'b1);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            check("idle_out", tx_out, 1);
            check("idle_busy", tx_busy, 0);
            check("idle_done", tx_done, 0);
            tick();
        end
    endtask

    // Entered at #1 after the acceptance edge; returns at the DONE cycle, or after an abort.
    task automatic run_word(input logic [31:0] w, input int abort_at, input bit disturb);
        logic       cap[$];
        logic [7:0] rx;
        int         j;
        int         base;
        build_line(w);
        j = 0;
        while (tx_done !== 1'b1 && j < WORD + 4) begin
            if (j < WORD) begin
                check("line", tx_out, exp_line[j]);
                check("busy", tx_busy, 1);
                check("ready_low", tx_ready, 0);
                check("byte_idx", byte_idx, j / (10 * C));
            end
            cap.push_back(tx_out);
            if (j == abort_at) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
                check("abort_out", tx_out, 1);
                check("abort_busy", tx_busy, 0);
                check("abort_ready", tx_ready, 1);
                check("abort_byte_idx", byte_idx, 0);
                for (int k = 0; k < 3 * C; k++) begin
                    check("abort_no_done", tx_done, 0);
                    check("abort_line_high", tx_out, 1);
                    tick();
                end
                return;
            end
            if (disturb && j == 37) begin
                tx_data  = $urandom;
                tx_valid = 1'b1;
            end
            if (disturb && j == 200) tx_valid = 1'b0;
            tick();
            j++;
        end
        // tx_done is high in the cycle that ends at edge j+1 counted from acceptance
        check("done_edge", j + 1, WORD + 1);
        check("done_out", tx_out, 1);
        check("done_busy", tx_busy, 0);
        check("done_ready", tx_ready, 1);
        check("done_byte_idx", byte_idx, 0);
        check("cap_len", cap.size(), WORD);
        if (cap.size() >= WORD) begin
            for (int b = 0; b < 4; b++) begin
                base = b * 10 * C;
                check("rx_start", cap[base + C/2], 0);
                for (int i = 0; i < 8; i++) rx[i] = cap[base + (1 + i) * C + C/2];
                check("rx_byte", rx, w[31-8*b -: 8]);
                check("rx_stop", cap[base + 9*C + C/2], 1);
            end
        end
    endtask

    task automatic send(input logic [31:0] w, input int abort_at, input bit disturb);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 4 * WORD) begin
            tick();
            n++;
        end
        check("ready_before_send", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = ~w;
        run_word(w, abort_at, disturb);
    endtask

    initial begin
        // reset held with a pending request
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = $urandom;
        tick();
        tick();
        check("rst_out", tx_out, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_byte_idx", byte_idx, 0);
        reset    = 1'b1;
        tx_valid = 1'b0;
        tick();
        check("rst_no_frame_busy", tx_busy, 0);
        check("rst_no_frame_out", tx_out, 1);

        send(32'h0000000F, -1, 1'b0);
        tick();
        idle_cycles(3);

        send(32'hA5C30F81, -1, 1'b0);
        tick();
        idle_cycles(3);

        // back-to-back: second word accepted in the DONE cycle
        tx_data  = 32'h00050000;
        tx_valid = 1'b1;
        tick();
        tx_data  = 32'h000F0000;
        run_word(32'h00050000, -1, 1'b0);
        tick();
        tx_valid = 1'b0;
        run_word(32'h000F0000, -1, 1'b0);
        tick();
        idle_cycles(3);

        // reset during byte 2 data bits, then a clean word
        send($urandom, 2 * 10 * C + C + 3 * C + 4, 1'b0);
        send(32'h000A0000, -1, 1'b0);
        tick();
        idle_cycles(3);

        // tx_data/tx_valid disturbed while busy
        send(32'h3C5A9612, -1, 1'b1);
        tick();
        idle_cycles(2 * C);

        for (int r = 0; r < 3; r++) begin
            send($urandom, -1, 1'b0);
            tick();
            idle_cycles(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
